uart_rx_datapath: RTL
=====================

// Module: uart_rx_datapath
// PURPOSE
//  Serial receiver for the single-cycle UART; consumes the 12-bit frame produced by the TX datapath on its
//  serial line: start(0), d0..d7 LSB first, parity, stop, stop(1,1). Synchronises rx_in, detects start, samples
//  mid-bit, rebuilds the byte, checks parity and both stop bits, presents byte plus status with a 1-cycle strobe.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per bit; even, >=4. H = CLKS_PER_BIT/2.
// PORTS
//  clk         in   1  clock, all state updates on rising edge
//  reset       in   1  synchronous, active-low reset
//  rx_in       in   1  serial line, idle high, asynchronous to clk
//  parity_sel  in   1  0: parity bit = ^data (even); 1: parity bit = ~^data (odd); same encoding as TX
//  rx_data     out  8  last received byte
//  rx_valid    out  1  1-cycle strobe: rx_data/parity_err/frame_err updated
//  parity_err  out  1  parity mismatch on last frame
//  frame_err   out  1  stop1 or stop2 sampled 0 on last frame
//  rx_busy     out  1  high whenever state != IDLE
// BEHAVIOUR
//  Reset (reset=0 at edge): state=IDLE, counters=0, sync flops=1; rx_data=0, rx_valid=0, parity_err=0,
//   frame_err=0, rx_busy=0. Applies mid-frame; partial frame discarded, no rx_valid.
//  Sync: 2-flop synchroniser, rx_s = rx_in delayed 2 edges. Only rx_s is used internally.
//  Counters: cnt (clog2(CLKS_PER_BIT) bits), bit_idx (3 bits), shift reg sr[7:0] filled LSB first.
//  FSM (one transition per edge):
//   IDLE    : rx_s==0 -> START, cnt<=0. Else stay.
//   START   : cnt++; at cnt==H-1: rx_s==0 -> DATA, cnt<=0, bit_idx<=0; rx_s==1 -> IDLE (glitch, no output).
//   DATA    : cnt++; at cnt==CLKS_PER_BIT-1: sr[bit_idx]<=rx_s, cnt<=0; bit_idx==7 -> PARITY else bit_idx++.
//   PARITY  : at cnt==CLKS_PER_BIT-1: latch p=rx_s, cnt<=0 -> STOP1.
//   STOP1   : at cnt==CLKS_PER_BIT-1: latch s1=rx_s, cnt<=0 -> STOP2.
//   STOP2   : at cnt==CLKS_PER_BIT-1: rx_data<=sr; parity_err<=(p != (^sr ^ parity_sel));
//             frame_err<=~(s1 & rx_s); rx_valid<=1; -> IDLE if s1&rx_s else BRK.
//   BRK     : wait; rx_s==1 -> IDLE. No start detection while in BRK.
//  Timing: E0 = first edge sampling rx_in=0. Samples at E0+2+H+k*CLKS_PER_BIT, k=0 start..11 stop2.
//   rx_valid high exactly the one cycle after edge E0+2+H+11*CLKS_PER_BIT (E0+186 for default).
//  rx_valid deasserts next cycle; rx_data/parity_err/frame_err hold until next rx_valid or reset.
//  Back-to-back frames (no idle gap) received: IDLE re-entered H cycles before next start edge reaches rx_s.
//  parity_sel sampled at STOP2 edge; caller holds it stable per frame.
//  Break (line held low): one rx_valid with frame_err=1, rx_data=0x00, then BRK until line returns high.
//  rx_busy is combinational from state (state != IDLE); high in BRK.
// TESTING
//  1 parity_sel=0, send 0xA5 (parity 0, stops 1,1) at N=16 -> rx_valid 1 cycle at E0+187, rx_data=0xA5, errs=0.
//  2 parity_sel=1, send 0x3C parity=1 -> no error; resend with parity=0 -> parity_err=1, rx_data=0x3C.
//  3 rx_in low 4 cycles then high -> START aborts at midpoint, rx_busy back to 0, no rx_valid.
//  4 stop2=0 then line held low 40 bit times -> single rx_valid, frame_err=1; no new frame until line high.
//  5 reset=0 one cycle during DATA bit 3 -> all outputs 0 next cycle; following clean 0x5A received correctly.
//  6 frames 0x00 then 0xFF with no idle gap -> two rx_valid pulses 12*16=192 cycles apart, both error-free.

Source files
------------

// File: rtl/uart_rx_datapath.sv
// uart_rx_datapath
//   Receives one 12-bit UART frame: start(0), d0..d7 LSB first, parity, stop1, stop2.
//   rx_in passes through a two-flop synchroniser. The start bit is confirmed at its
//   midpoint, and every later bit is sampled one bit period after the previous sample.
//   At the second stop bit the byte and its status are published with a one-cycle strobe.
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous, active-low reset
//   rx_in       serial line, idle high, asynchronous to clk
//   parity_sel  0: even parity (bit = ^data), 1: odd parity (bit = ~^data)
//   rx_data     last received byte
//   rx_valid    one-cycle strobe when rx_data / parity_err / frame_err update
//   parity_err  parity mismatch on the last frame
//   frame_err   stop1 or stop2 sampled low on the last frame
//   rx_busy     high whenever the receiver is not idle
//
// state  | meaning
// IDLE   | waiting for the line to go low
// START  | counting to the start-bit midpoint, then confirming it is still low
// DATA   | sampling d0..d7, one bit period apart
// PARITY | sampling the parity bit
// STOP1  | sampling the first stop bit
// STOP2  | sampling the second stop bit and publishing the result
// BRK    | stop bit was low; waiting for the line to return high

module uart_rx_datapath #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       parity_sel,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);
    localparam int H     = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP1  = 3'd4;
    localparam logic [2:0] S_STOP2  = 3'd5;
    localparam logic [2:0] S_BRK    = 3'd6;

    logic [2:0]       state;
    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       sr;
    logic             p_bit;
    logic             s1_bit;
    logic             bit_end;

    assign bit_end = (cnt == CNT_END);
    assign rx_busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            cnt        <= '0;
            bit_idx    <= 3'd0;
            sr         <= 8'h00;
            p_bit      <= 1'b0;
            s1_bit     <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta  <= rx_in;
            rx_s     <= rx_meta;
            rx_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= S_DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            // Low pulse shorter than half a bit: treat as noise.
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        sr[bit_idx] <= rx_s;
                        cnt         <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_PARITY;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        p_bit <= rx_s;
                        cnt   <= '0;
                        state <= S_STOP1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP1: begin
                    if (bit_end) begin
                        s1_bit <= rx_s;
                        cnt    <= '0;
                        state  <= S_STOP2;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP2: begin
                    if (bit_end) begin
                        cnt        <= '0;
                        rx_data    <= sr;
                        parity_err <= (p_bit != (^sr ^ parity_sel));
                        frame_err  <= ~(s1_bit & rx_s);
                        rx_valid   <= 1'b1;
                        // A low stop bit may be a held break; do not re-arm until the line idles.
                        state      <= (s1_bit & rx_s) ? S_IDLE : S_BRK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BRK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
